// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the serial instruction-memory loader.
// Derived sizes follow the default word-index width; the top recomputes them from its parameter.
package instr_mem_loader_pkg;

  localparam int unsigned DEF_INSTR_ADDR_BITS = 5;
  localparam int unsigned DEF_WORD_COUNT      = 1 << DEF_INSTR_ADDR_BITS;
  localparam int unsigned DEF_MEM_BYTES       = DEF_WORD_COUNT * 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } load_state_t;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: tracks the byte lane and raises word_ready
// in the same cycle the fourth byte is accepted, presenting the complete word.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  lane_q;
  logic [23:0] low_q;

  // Lanes 0..2 are stored; lane 3 is taken straight from the bus when the word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      low_q  <= 24'd0;
    end else if (clear) begin
      lane_q <= 2'd0;
      low_q  <= 24'd0;
    end else if (byte_valid) begin
      case (lane_q)
        2'd0:    low_q[7:0]   <= byte_data;
        2'd1:    low_q[15:8]  <= byte_data;
        2'd2:    low_q[23:16] <= byte_data;
        default: ;
      endcase
      lane_q <= lane_q + 2'd1;
    end
  end

  assign word_ready = byte_valid && (lane_q == 2'd3);
  assign word       = {byte_data, low_q};

endmodule

// File: rtl/instr_mem_loader.sv
// Serial program loader: packs a byte stream into words, writes them to instruction
// memory at word-aligned addresses, then verifies a trailing XOR checksum byte.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned INSTR_ADDR_BITS = DEF_INSTR_ADDR_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [INSTR_ADDR_BITS:0]   len_words,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       cpu_hold,
  output logic                       busy,
  output logic                       done,
  output logic                       cksum_err
);

  localparam logic [INSTR_ADDR_BITS:0] FULL_COUNT = {1'b1, {INSTR_ADDR_BITS{1'b0}}};

  load_state_t                state_q, state_d;
  logic [INSTR_ADDR_BITS:0]   remaining_q;
  logic [INSTR_ADDR_BITS-1:0] index_q;
  logic [7:0]                 acc_q;

  logic        accept;
  logic        start_ok;
  logic        load_byte;
  logic        word_ready;
  logic [31:0] packed_word;

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state_q == IDLE);
  assign load_byte = accept && (state_q == LOAD);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_valid (load_byte),
    .byte_data  (rx_data),
    .word_ready (word_ready),
    .word       (packed_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // remaining_q is already decremented during the write cycle, so zero there marks the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (mem_we && (remaining_q == '0)) state_d = CHECK;
      CHECK:   if (rx_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    case (state_q)
      LOAD:    rx_ready = !mem_we;
      CHECK:   rx_ready = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
    if (state_q != IDLE) begin
      busy     = 1'b1;
      cpu_hold = 1'b1;
    end
  end

  // Word counter, write port registers and checksum; address/data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      index_q     <= '0;
      acc_q       <= 8'd0;
      cksum_err   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
    end else begin
      mem_we <= word_ready;
      if (start_ok) begin
        remaining_q <= (len_words == '0) ? FULL_COUNT : len_words;
        index_q     <= '0;
        acc_q       <= 8'd0;
        cksum_err   <= 1'b0;
      end
      if (load_byte) begin
        acc_q <= acc_q ^ rx_data;
      end
      if (word_ready) begin
        mem_wdata   <= packed_word;
        mem_addr    <= {{(30 - INSTR_ADDR_BITS){1'b0}}, index_q, 2'b00};
        index_q     <= index_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      if (accept && (state_q == CHECK)) begin
        cksum_err <= ((acc_q ^ rx_data) != 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a word/checksum reference model.
module tb_instr_mem_loader;

  localparam int IAB = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IAB:0]  len_words = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          cksum_err;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [63:0] writeQ[$];
  logic [31:0] planWords[32];

  instr_mem_loader #(.INSTR_ADDR_BITS(IAB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len_words (len_words),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .cksum_err (cksum_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Record every memory write; the read port must be stalled in that cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      writeQ.push_back({mem_addr, mem_wdata});
      checkOutput("ready_low_in_write", 32'(rx_ready), 32'd0);
    end
  end

  task automatic sendByte(input logic [7:0] b);
    bit taken = 1'b0;
    int waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!taken && waited < 64) begin
      #1;
      taken = rx_ready;
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if (!taken) checkOutput("byte_accept_timeout", 32'(taken), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_cksum_err"}, 32'(cksum_err), 32'd0);
  endtask

  // Runs one complete load of planWords[0..nWords-1] and compares against the model.
  task automatic applyStimulus(input int nWords, input logic [IAB:0] lenField,
                               input logic [7:0] cksumFlip, input int gapPct, input bit pokeStart);
    logic [7:0]  xorSum = 8'd0;
    logic [7:0]  b;
    logic [63:0] got;
    logic [31:0] expAddr;
    writeQ.delete();
    @(negedge clk);
    start     = 1'b1;
    len_words = lenField;
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_after_start", 32'(cpu_hold), 32'd1);
    checkOutput("cksum_err_cleared", 32'(cksum_err), 32'd0);
    for (int i = 0; i < nWords; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'((planWords[i] >> (8 * k)) & 32'hFF);
        xorSum = xorSum ^ b;
        if (pokeStart && i == 0 && k == 2) begin
          rx_valid  = 1'b0;
          start     = 1'b1;
          len_words = 1;
          @(negedge clk);
          start = 1'b0;
          repeat (4) @(negedge clk);
          checkOutput("busy_after_ignored_start", 32'(busy), 32'd1);
        end else if ($urandom_range(99) < gapPct) begin
          rx_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        sendByte(b);
      end
    end
    sendByte(xorSum ^ cksumFlip);
    rx_valid = 1'b0;
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("hold_idle", 32'(cpu_hold), 32'd0);
    checkOutput("cksum_err", 32'(cksum_err), 32'(cksumFlip != 8'd0));
    checkOutput("write_count", 32'(writeQ.size()), 32'(nWords));
    for (int i = 0; i < nWords && writeQ.size() > 0; i++) begin
      got = writeQ.pop_front();
      expAddr = 32'((i % 32) * 4);
      checkOutput("write_addr", got[63:32], expAddr);
      checkOutput("write_data", got[31:0], planWords[i]);
    end
    checkOutput("addr_held", mem_addr, 32'(((nWords - 1) % 32) * 4));
    checkOutput("wdata_held", mem_wdata, planWords[nWords - 1]);
  endtask

  initial begin
    int n;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    planWords[0] = 32'h00000013;
    applyStimulus(1, 1, 8'h00, 0, 1'b0);

    applyStimulus(1, 1, 8'h01, 0, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    checkOutput("idle_not_ready", 32'(rx_ready), 32'd0);
    checkOutput("cksum_err_sticky", 32'(cksum_err), 32'd1);
    rx_valid = 1'b0;

    planWords[0] = 32'h00500093;
    planWords[1] = 32'h00100113;
    planWords[2] = 32'h002081B3;
    applyStimulus(3, 3, 8'h00, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) planWords[i] = $urandom;
      applyStimulus(n, 6'(n), (r == 2) ? 8'($urandom_range(1, 255)) : 8'h00, 30, 1'b0);
    end

    for (int i = 0; i < 32; i++) planWords[i] = $urandom;
    applyStimulus(32, 0, 8'h00, 20, 1'b0);

    for (int i = 0; i < 3; i++) planWords[i] = $urandom;
    applyStimulus(3, 3, 8'h00, 0, 1'b1);

    // Abort mid-load: asynchronous reset between clock edges.
    @(negedge clk);
    start     = 1'b1;
    len_words = 3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) sendByte(8'(k + 1));
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    writeQ.delete();
    rx_valid = 1'b1;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    checkOutput("no_write_after_reset", 32'(writeQ.size()), 32'd0);
    checkOutput("idle_after_reset", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
